// File: rtl/median_column_feeder.sv
// Median filter front end: turns a raster pixel stream into vertically aligned
// 3-pixel columns (rows r-2, r-1, r) using two line buffers.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   pix_in/pix_valid/pix_sof   input pixel stream; pix_sof marks pixel (0,0)
//   pix_ready                  feeder accepts pix_in this cycle
//   col_out0/1/2               column pixels: row r-2, r-1, r
//   col_valid/col_ready        output handshake
//   col_first                  first column since the last pix_sof
//   col_last                   column taken at x = IMG_WIDTH-1
module median_column_feeder #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned IMG_WIDTH  = 640,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] pix_in,
  input  logic                  pix_valid,
  input  logic                  pix_sof,
  output logic                  pix_ready,
  output logic [DATA_WIDTH-1:0] col_out0,
  output logic [DATA_WIDTH-1:0] col_out1,
  output logic [DATA_WIDTH-1:0] col_out2,
  output logic                  col_valid,
  input  logic                  col_ready,
  output logic                  col_first,
  output logic                  col_last
);

  typedef enum logic [1:0] {StIdle, StFill, StRun} state_e;

  localparam logic [ADDR_WIDTH-1:0] XLast = ADDR_WIDTH'(IMG_WIDTH - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] x_q, x_d, wr_x;
  logic [1:0]            row_q, row_d, cur_row;
  logic                  first_pend_q, first_pend_d;

  logic [DATA_WIDTH-1:0] lb0 [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] lb1 [IMG_WIDTH];

  logic [DATA_WIDTH-1:0] out0_q, out1_q, out2_q;
  logic                  valid_q, first_q, last_q;

  logic accept, proc, load, row_end;

  // A pix_sof pixel is always processed as (0,0) of row 0, whatever the counters say.
  always_comb begin
    accept  = pix_valid & pix_ready;
    wr_x    = pix_sof ? '0 : x_q;
    cur_row = pix_sof ? 2'd0 : row_q;
    proc    = accept & (pix_sof | (state_q != StIdle));
    load    = accept & ~pix_sof & (state_q == StRun);
    row_end = (wr_x == XLast);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (accept & pix_sof) begin
      state_d = StFill;
    end else if (proc & (state_q == StFill) & (row_q == 2'd1) & row_end) begin
      state_d = StRun;
    end
  end

  // Output logic
  always_comb begin
    pix_ready = ~valid_q | col_ready;
    col_out0  = out0_q;
    col_out1  = out1_q;
    col_out2  = out2_q;
    col_valid = valid_q;
    col_first = first_q;
    col_last  = last_q;
  end

  // Position counters; row count saturates at 2 once the buffers hold two rows.
  always_comb begin
    x_d          = x_q;
    row_d        = row_q;
    first_pend_d = first_pend_q;
    if (proc) begin
      x_d   = row_end ? '0 : wr_x + 1'b1;
      row_d = cur_row;
      if (row_end && (cur_row != 2'd2)) begin
        row_d = cur_row + 2'd1;
      end
    end
    if (accept & pix_sof) begin
      first_pend_d = 1'b1;
    end else if (load) begin
      first_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q          <= '0;
      row_q        <= 2'd0;
      first_pend_q <= 1'b0;
    end else begin
      x_q          <= x_d;
      row_q        <= row_d;
      first_pend_q <= first_pend_d;
    end
  end

  // Line buffers shift one row down per write; reads see the pre-write contents.
  always_ff @(posedge clk) begin
    if (proc) begin
      lb0[wr_x] <= lb1[wr_x];
      lb1[wr_x] <= pix_in;
    end
  end

  // Output register. Stalls cannot collide with a load: pix_ready is low while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      out0_q  <= '0;
      out1_q  <= '0;
      out2_q  <= '0;
      valid_q <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
    end else if (load) begin
      out0_q  <= lb0[wr_x];
      out1_q  <= lb1[wr_x];
      out2_q  <= pix_in;
      valid_q <= 1'b1;
      first_q <= first_pend_q;
      last_q  <= row_end;
    end else if (col_ready) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_median_column_feeder.sv
module tb_median_column_feeder;

  localparam int W = 4;

  typedef struct packed {
    logic [7:0] c0;
    logic [7:0] c1;
    logic [7:0] c2;
    logic       first;
    logic       last;
  } col_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] pix_in = '0;
  logic       pix_valid = 1'b0;
  logic       pix_sof = 1'b0;
  logic       pix_ready;
  logic [7:0] col_out0, col_out1, col_out2;
  logic       col_valid;
  logic       col_ready = 1'b1;
  logic       col_first, col_last;

  int checks = 0;
  int errors = 0;
  int ready_mode = 0;  // 0: always ready, 1: never ready, 2: random

  // Frame-coordinate reference model
  logic [7:0] fr [3][W];
  int         mx, my;
  bit         in_frame = 1'b0;
  bit         started = 1'b0;
  col_t       exp_q[$];
  col_t       log_q[$];

  median_column_feeder #(
    .DATA_WIDTH(8),
    .IMG_WIDTH (W),
    .ADDR_WIDTH(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .pix_in   (pix_in),
    .pix_valid(pix_valid),
    .pix_sof  (pix_sof),
    .pix_ready(pix_ready),
    .col_out0 (col_out0),
    .col_out1 (col_out1),
    .col_out2 (col_out2),
    .col_valid(col_valid),
    .col_ready(col_ready),
    .col_first(col_first),
    .col_last (col_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s timed out", name);
  endtask

  function automatic void model_accept(input logic [7:0] p, input logic sof);
    col_t c;
    if (sof) begin
      in_frame = 1'b1;
      mx = 0;
      my = 0;
    end
    if (!in_frame) return;
    fr[my % 3][mx] = p;
    if (my >= 2) begin
      c.c0    = fr[(my - 2) % 3][mx];
      c.c1    = fr[(my - 1) % 3][mx];
      c.c2    = p;
      c.first = (my == 2) && (mx == 0);
      c.last  = (mx == W - 1);
      exp_q.push_back(c);
    end
    mx++;
    if (mx == W) begin
      mx = 0;
      my++;
    end
  endfunction

  // Compare process: evaluates the cycle that ends at the next rising edge.
  always @(negedge clk) begin
    col_t act;
    bit   exp_rdy;
    act     = {col_out0, col_out1, col_out2, col_first, col_last};
    exp_rdy = (exp_q.size() == 0) || col_ready;
    if (started) begin
      chk("pix_ready", {31'b0, pix_ready}, {31'b0, exp_rdy});
      chk("col_valid", {31'b0, col_valid}, {31'b0, exp_q.size() != 0});
      if (col_valid && exp_q.size() != 0) begin
        chk("column", {6'b0, act}, {6'b0, exp_q[0]});
        if (col_ready) begin
          log_q.push_back(act);
          void'(exp_q.pop_front());
        end
      end
    end
    if (rst) begin
      started  = 1'b1;
      in_frame = 1'b0;
      exp_q.delete();
    end else if (started && pix_valid && exp_rdy) begin
      model_accept(pix_in, pix_sof);
    end
  end

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       col_ready = 1'b1;
      1:       col_ready = 1'b0;
      default: col_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  task automatic send(input logic [7:0] p, input logic sof, output int waited);
    waited    = 0;
    pix_in    = p;
    pix_sof   = sof;
    pix_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (pix_ready) begin
        @(posedge clk);
        #1;
        break;
      end
      waited++;
      if (waited > 200) begin
        fail_now("send");
        break;
      end
    end
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
  endtask

  task automatic send_rows(input int base, input int r0, input int r1, input bit sof_first);
    int w;
    for (int r = r0; r <= r1; r++) begin
      for (int c = 0; c < W; c++) begin
        send(8'(base + 16 * r + c), sof_first && r == r0 && c == 0, w);
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    for (n = 0; n < 100; n++) begin
      @(negedge clk);
      if (!col_valid) break;
    end
    @(posedge clk);
    #1;
    if (n == 100) fail_now("drain");
  endtask

  task automatic chk_col(input string nm, input int idx, input logic [7:0] c0,
                         input logic [7:0] c1, input logic [7:0] c2, input logic f,
                         input logic l);
    col_t want;
    want = {c0, c1, c2, f, l};
    if (idx >= log_q.size()) begin
      fail_now(nm);
    end else begin
      chk(nm, {6'b0, log_q[idx]}, {6'b0, want});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int w;
    int n;
    int rows;
    int npix;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", {31'b0, col_valid}, 0);
    chk("rst_outs", {8'b0, col_out0, col_out1, col_out2}, 0);
    chk("rst_ready", {31'b0, pix_ready}, 1);
    @(posedge clk);
    #1;

    // Pixels before any pix_sof are accepted and dropped
    send(8'hAA, 1'b0, w);
    chk("junk_ready_aa", w, 0);
    send(8'hBB, 1'b0, w);
    chk("junk_ready_bb", w, 0);
    idle(3);
    chk("junk_no_cols", log_q.size(), 0);

    // Frame A: rows 0..3
    send_rows(0, 0, 3, 1'b1);
    drain();
    chk("frameA_count", log_q.size(), 8);
    chk_col("A_first", 0, 8'h00, 8'h10, 8'h20, 1'b1, 1'b0);
    chk_col("A_c3", 3, 8'h03, 8'h13, 8'h23, 1'b0, 1'b1);
    chk_col("A_r3c0", 4, 8'h10, 8'h20, 8'h30, 1'b0, 1'b0);
    chk_col("A_r3c3", 7, 8'h13, 8'h23, 8'h33, 1'b0, 1'b1);

    // Frame B: back-pressure during row 2
    log_q.delete();
    ready_mode = 1;
    send_rows(0, 0, 1, 1'b1);
    fork
      send_rows(0, 2, 2, 1'b0);
      begin
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!col_valid && n < 100);
        if (!col_valid) fail_now("stall_wait");
        for (int i = 0; i < 5; i++) begin
          chk("stall_ready", {31'b0, pix_ready}, 0);
          chk("stall_hold", {7'b0, col_out0, col_out1, col_out2, col_first}, {7'b0, 24'h001020, 1'b1});
          @(negedge clk);
        end
        ready_mode = 0;
      end
    join
    drain();
    chk("stall_count", log_q.size(), 4);
    chk_col("B_c0", 0, 8'h00, 8'h10, 8'h20, 1'b1, 1'b0);
    chk_col("B_c1", 1, 8'h01, 8'h11, 8'h21, 1'b0, 1'b0);
    chk_col("B_c3", 3, 8'h03, 8'h13, 8'h23, 1'b0, 1'b1);

    // Frame C: pix_sof re-asserted at row 2 column 2
    log_q.delete();
    send_rows(0, 0, 1, 1'b1);
    send(8'h20, 1'b0, w);
    send(8'h21, 1'b0, w);
    send_rows(8'h80, 0, 1, 1'b1);
    drain();
    chk("resof_no_cols", log_q.size(), 2);
    send_rows(8'h80, 2, 2, 1'b0);
    drain();
    chk("resof_count", log_q.size(), 6);
    chk_col("C_new_first", 2, 8'h80, 8'h90, 8'hA0, 1'b1, 1'b0);
    chk_col("C_new_last", 5, 8'h83, 8'h93, 8'hA3, 1'b0, 1'b1);

    // Frame D: reset mid row 3
    send_rows(0, 0, 2, 1'b1);
    send(8'h30, 1'b0, w);
    send(8'h31, 1'b0, w);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_valid", {31'b0, col_valid}, 0);
    chk("midrst_outs", {8'b0, col_out0, col_out1, col_out2}, 0);
    chk("midrst_ready", {31'b0, pix_ready}, 1);
    @(posedge clk);
    #1;
    log_q.delete();
    send(8'h55, 1'b0, w);
    chk("post_rst_drop", w, 0);
    send(8'h66, 1'b0, w);
    send(8'h77, 1'b0, w);
    drain();
    chk("post_rst_no_cols", log_q.size(), 0);
    send_rows(8'h40, 0, 2, 1'b1);
    drain();
    chk_col("D_first", 0, 8'h40, 8'h50, 8'h60, 1'b1, 1'b0);

    // Random frames with random back-pressure and input gaps
    ready_mode = 2;
    for (int it = 0; it < 10; it++) begin
      rows = $urandom_range(2, 5);
      npix = (it % 3 == 0) ? $urandom_range(1, rows * W) : rows * W;
      for (int k = 0; k < npix; k++) begin
        if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
        send(8'($urandom_range(0, 255)), k == 0, w);
      end
    end
    ready_mode = 0;
    idle(2);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
